// File: rtl/gray_pkg.sv
// Shared definitions for the gray counter family: decoder FSM states and
// width-generic gray/binary conversion helpers (operands zero-extended to GRAY_MAX_W).
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 64;
  localparam int unsigned STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_INIT  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } gray_state_e;

  // Zero high bits do not disturb the low bits of the result.
  function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = g;
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin_to_gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_to_bin.sv
// Combinational gray-to-binary converter: each binary bit is the XOR of all
// gray bits at or above its position.
module gray_to_bin #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] gray,
  output logic [DATA_WIDTH-1:0] bin_c
);

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
    assign bin_c[i] = ^gray[DATA_WIDTH-1:i];
  end

endmodule

// File: rtl/gray_sync_decoder.sv
// Brings a foreign-domain gray count through a synchronizer, decodes it to
// binary and reports per-capture increments with a sticky over-step flag.
module gray_sync_decoder
  import gray_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_STEP    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  err_clr,
  input  logic [DATA_WIDTH-1:0] gray_in,
  output logic [DATA_WIDTH-1:0] bin_out,
  output logic [DATA_WIDTH-1:0] delta_out,
  output logic                  change,
  output logic                  step_err,
  output logic                  locked
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned CMP_W = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;

  logic [DATA_WIDTH-1:0] sg;
  logic [DATA_WIDTH-1:0] g;
  logic [DATA_WIDTH-1:0] step;

  gray_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] bin_d, delta_d;
  logic                  change_d, err_d, locked_d;

  // Synchronizer chain; free-running regardless of en and FSM state.
  for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
    logic [DATA_WIDTH-1:0] q;
    if (i == 0) begin : g_first
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= gray_in;
      end
    end else begin : g_next
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= g_sync[i-1].q;
      end
    end
  end

  assign sg = g_sync[SYNC_STAGES-1].q;

  gray_to_bin #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_gray_to_bin (
    .gray  (sg),
    .bin_c (g)
  );

  // Next-state and output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bin_d    = bin_out;
    delta_d  = delta_out;
    change_d = 1'b0;
    err_d    = step_err;
    locked_d = locked;
    step     = g - bin_out;

    // Clear first so a same-edge violation below still sets the flag.
    if (err_clr) err_d = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SYNC_STAGES - 1)) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        bin_d    = g;
        delta_d  = '0;
        locked_d = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (en) begin
          bin_d    = g;
          delta_d  = step;
          change_d = (g != bin_out);
          if (CMP_W'(step) > CMP_W'(MAX_STEP)) err_d = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      bin_out   <= '0;
      delta_out <= '0;
      change    <= 1'b0;
      step_err  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_out   <= bin_d;
      delta_out <= delta_d;
      change    <= change_d;
      step_err  <= err_d;
      locked    <= locked_d;
    end
  end

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Bench for gray_sync_decoder: directed vector table, reset/relock sequence,
// and randomized forward counting compared against a delay-queue reference model.
module tb_gray_sync_decoder;

  localparam int unsigned DW   = 8;
  localparam int unsigned SYNC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b1;
  logic          err_clr = 1'b0;
  logic [DW-1:0] gray_in = '0;

  logic [DW-1:0] bin_out, delta_out, bin4, delta4;
  logic          change, step_err, locked, change4, step_err4, locked4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gray_sync_decoder #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .MAX_STEP(1)) dut (
    .clk(clk), .rst(rst), .en(en), .err_clr(err_clr), .gray_in(gray_in),
    .bin_out(bin_out), .delta_out(delta_out), .change(change),
    .step_err(step_err), .locked(locked)
  );

  gray_sync_decoder #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC), .MAX_STEP(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .err_clr(err_clr), .gray_in(gray_in),
    .bin_out(bin4), .delta_out(delta4), .change(change4),
    .step_err(step_err4), .locked(locked4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Binary value of a gray code: XOR of the code with all its right shifts.
  function automatic logic [DW-1:0] ref_g2b(input logic [DW-1:0] gv);
    logic [DW-1:0] b;
    b = '0;
    for (int k = 0; k < int'(DW); k++) b = b ^ (gv >> k);
    return b;
  endfunction

  // Reference model: the value captured on an edge is gray_in as it stood SYNC edges earlier.
  logic [DW-1:0] hist[$];
  logic [DW-1:0] m_bin = '0, m_delta = '0, m_sample, m_step;
  logic          m_change = 1'b0, m_err1 = 1'b0, m_err4 = 1'b0, m_locked = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist.delete();
      m_bin = '0; m_delta = '0; m_change = 1'b0;
      m_err1 = 1'b0; m_err4 = 1'b0; m_locked = 1'b0;
    end else begin
      hist.push_back(gray_in);
      if (hist.size() > SYNC + 1) void'(hist.pop_front());
      m_change = 1'b0;
      if (err_clr) begin m_err1 = 1'b0; m_err4 = 1'b0; end
      if (!m_locked) begin
        if (hist.size() == SYNC + 1) begin
          m_bin = ref_g2b(hist[0]); m_delta = '0; m_locked = 1'b1;
        end
      end else if (en) begin
        m_sample = ref_g2b(hist[0]);
        m_step   = m_sample - m_bin;
        m_change = (m_step != 0);
        if (m_step > 1) m_err1 = 1'b1;
        if (m_step > 4) m_err4 = 1'b1;
        m_delta = m_step;
        m_bin   = m_sample;
      end
    end
  end

  always @(negedge clk) begin
    check("mdl_bin",    32'(bin_out),   32'(m_bin));
    check("mdl_delta",  32'(delta_out), 32'(m_delta));
    check("mdl_change", 32'(change),    32'(m_change));
    check("mdl_err",    32'(step_err),  32'(m_err1));
    check("mdl_locked", 32'(locked),    32'(m_locked));
    check("mdl_bin4",   32'(bin4),      32'(m_bin));
    check("mdl_err4",   32'(step_err4), 32'(m_err4));
  end

  typedef struct {
    logic [DW-1:0] gray;
    logic          en;
    logic          clr;
    int            hold;
    logic [DW-1:0] bin;
    logic [DW-1:0] delta;
    int            pulses;
    logic          err1;
    logic          err4;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [DW-1:0] gv, input logic e, input logic c, input int h,
                              input logic [DW-1:0] b, input logic [DW-1:0] d, input int p,
                              input logic e1, input logic e4);
    vec_t v;
    v.gray = gv; v.en = e; v.clr = c; v.hold = h; v.bin = b; v.delta = d;
    v.pulses = p; v.err1 = e1; v.err4 = e4;
    return v;
  endfunction

  int            pulses;
  logic [DW-1:0] cur_bin;

  initial begin
    // gray, en, clr, hold, bin, delta, pulses, err(MAX_STEP=1), err(MAX_STEP=4)
    tbl.push_back(mk(8'h00, 1, 0, 3,   0,   0, 0, 0, 0));
    tbl.push_back(mk(8'h01, 1, 0, 3,   1,   1, 1, 0, 0));
    tbl.push_back(mk(8'h03, 1, 0, 3,   2,   1, 1, 0, 0));
    tbl.push_back(mk(8'h02, 1, 0, 3,   3,   1, 1, 0, 0));
    tbl.push_back(mk(8'h07, 1, 0, 3,   5,   2, 1, 1, 0));
    tbl.push_back(mk(8'h07, 1, 1, 1,   5,   0, 0, 0, 0));
    tbl.push_back(mk(8'h07, 1, 0, 3,   5,   0, 0, 0, 0));
    tbl.push_back(mk(8'h80, 1, 0, 3, 255, 250, 1, 1, 1));
    tbl.push_back(mk(8'h80, 1, 1, 1, 255,   0, 0, 0, 0));
    tbl.push_back(mk(8'h80, 1, 0, 3, 255,   0, 0, 0, 0));
    tbl.push_back(mk(8'h00, 1, 0, 3,   0,   1, 1, 0, 0));
    tbl.push_back(mk(8'h01, 1, 0, 3,   1,   1, 1, 0, 0));
    tbl.push_back(mk(8'h03, 1, 0, 3,   2,   1, 1, 0, 0));
    tbl.push_back(mk(8'h02, 1, 0, 3,   3,   1, 1, 0, 0));
    tbl.push_back(mk(8'h06, 1, 0, 3,   4,   1, 1, 0, 0));
    tbl.push_back(mk(8'h04, 0, 0, 4,   4,   1, 0, 0, 0));
    tbl.push_back(mk(8'h04, 1, 0, 1,   7,   3, 1, 1, 0));
    tbl.push_back(mk(8'h04, 1, 0, 3,   7,   0, 0, 1, 0));
    tbl.push_back(mk(8'h04, 1, 1, 1,   7,   0, 0, 0, 0));
    tbl.push_back(mk(8'h0D, 1, 0, 2,   7,   0, 0, 0, 0));
    tbl.push_back(mk(8'h0D, 1, 1, 1,   9,   2, 1, 1, 0));

    // Reset state, then lock on the third edge after release.
    #2;
    check("rst_bin",    32'(bin_out),   0);
    check("rst_delta",  32'(delta_out), 0);
    check("rst_locked", 32'(locked),    0);
    @(negedge clk); #1 rst = 1'b1;
    pulses = 0;
    repeat (2) begin @(negedge clk); if (change) pulses++; end
    check("lock_early", 32'(locked), 0);
    @(negedge clk); if (change) pulses++;
    check("lock_edge3",  32'(locked),   1);
    check("lock_bin",    32'(bin_out),  0);
    check("lock_err",    32'(step_err), 0);
    check("lock_pulses", 32'(pulses),   0);
    #1;

    foreach (tbl[k]) begin
      gray_in = tbl[k].gray; en = tbl[k].en; err_clr = tbl[k].clr;
      pulses = 0;
      repeat (tbl[k].hold) begin @(negedge clk); if (change) pulses++; end
      check($sformatf("v%0d_bin", k),    32'(bin_out),   32'(tbl[k].bin));
      check($sformatf("v%0d_delta", k),  32'(delta_out), 32'(tbl[k].delta));
      check($sformatf("v%0d_pulses", k), 32'(pulses),    32'(tbl[k].pulses));
      check($sformatf("v%0d_err", k),    32'(step_err),  32'(tbl[k].err1));
      check($sformatf("v%0d_err4", k),   32'(step_err4), 32'(tbl[k].err4));
      #1;
    end
    err_clr = 1'b0; en = 1'b1;

    // Asynchronous reset mid-run, then relock onto bin 255.
    gray_in = 8'h80;
    rst = 1'b0;
    #1;
    check("mid_rst_bin",    32'(bin_out),   0);
    check("mid_rst_delta",  32'(delta_out), 0);
    check("mid_rst_err",    32'(step_err),  0);
    check("mid_rst_locked", 32'(locked),    0);
    check("mid_rst_locked4", 32'(locked4),  0);
    @(negedge clk); #1 rst = 1'b1;
    pulses = 0;
    repeat (2) begin @(negedge clk); if (change) pulses++; end
    check("relock_early", 32'(locked), 0);
    @(negedge clk); if (change) pulses++;
    check("relock_locked", 32'(locked),   1);
    check("relock_bin",    32'(bin_out),  255);
    check("relock_delta",  32'(delta_out), 0);
    check("relock_err",    32'(step_err), 0);
    check("relock_pulses", 32'(pulses),   0);
    #1;

    // Randomized forward counting with occasional jumps, holds, clears and one reset.
    cur_bin = 8'd255;
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 9) == 0) cur_bin = 8'($urandom_range(0, 255));
      else                           cur_bin = cur_bin + 8'($urandom_range(0, 3));
      gray_in = cur_bin ^ (cur_bin >> 1);
      en      = ($urandom_range(0, 7) != 0);
      err_clr = ($urandom_range(0, 9) == 0);
      if (it == 150) begin
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
      end
      repeat ($urandom_range(1, 4)) @(negedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_sync_decoder.md
Name: gray_sync_decoder

Overview:
Consumer stage for the gray_counter output. It brings a gray-coded count from a foreign or asynchronous source into the local clock domain through a multi-stage synchronizer, then converts it to binary. It reports per-sample increments and flags jumps larger than the allowed step. Typical uses are FIFO pointer crossing and rate measurement on a counter running in another domain.

Parameters:
DATA_WIDTH, 8, width of gray input and all count outputs
SYNC_STAGES, 2, synchronizer flop depth (legal values 2..4)
MAX_STEP, 1, largest binary increment per accepted sample that does not raise step_err

Ports:
clk  in  1  local clock; all state changes on rising edge
rst  in  1  asynchronous reset, active-low (rst=0 resets, release is synchronous to clk)
en  in  1  capture enable; synchronizer always runs
err_clr  in  1  clears sticky step_err
gray_in  in  DATA_WIDTH  gray-coded count from the upstream counter (asynchronous to clk)
bin_out  out  DATA_WIDTH  last captured count, binary
delta_out  out  DATA_WIDTH  (new - previous) mod 2^DATA_WIDTH at the last capture
change  out  1  one-cycle pulse; bin_out updated with a different value
step_err  out  1  sticky; some capture had delta_out > MAX_STEP
locked  out  1  high once the first valid sample is loaded

Behaviour:
- Reset (rst=0, asynchronous): sync chain, bin_out, delta_out, change, step_err, locked all 0; FSM to INIT; stage counter 0.
- Sync chain: s[0] <= gray_in; s[i] <= s[i-1] each edge, independent of en and FSM state. Sample point is s[SYNC_STAGES-1], called sg.
- g = gray_to_bin(sg): b[MSB]=g[MSB]; b[i]=b[i+1]^g[i].
- FSM INIT: outputs held at reset values; counter increments each edge; goes to PRIME on the edge where counter reaches SYNC_STAGES-1, i.e. after SYNC_STAGES edges.
- FSM PRIME, one edge: bin_out <= g; delta_out <= 0; change stays 0; no error check; locked <= 1; next state RUN.
- Hence locked rises on edge SYNC_STAGES+1 after reset release.
- FSM RUN, en=1: bin_out <= g; delta_out <= g - bin_out (mod 2^DATA_WIDTH); change <= (g != bin_out); if that delta > MAX_STEP then step_err <= 1.
- FSM RUN, en=0: bin_out and delta_out hold; change <= 0. On re-enable, delta covers all movement during the hold.
- Latency: a stable gray_in change is visible on bin_out, with change=1, SYNC_STAGES+1 edges later.
- Wrap: 2^DATA_WIDTH-1 -> 0 yields delta 1, no error. Only forward counting is legal; a backward move shows as a large delta and flags.
- step_err: err_clr=1 clears it on the next edge. If err_clr coincides with a new violation, set wins and step_err stays 1.
- Reset mid-RUN: immediate return to reset values and INIT; relock follows the normal sequence. The first sample after relock is never flagged.
- No arithmetic beyond DATA_WIDTH bits: subtraction is modular and unsigned. MAX_STEP is compared unsigned.

Decomposition:
- Shared package gray_pkg: FSM state encodings ST_INIT/ST_PRIME/ST_RUN (2-bit); gray_to_bin and bin_to_gray functions, width-generic via DATA_WIDTH. The gray_counter also uses these.
- One sub-module, gray_to_bin: combinational, parameterised by DATA_WIDTH, instanced on sg.
- The sync chain stays inline, generate loop over SYNC_STAGES.

Test Plan (DATA_WIDTH=8, SYNC_STAGES=2, MAX_STEP=1 unless noted):
1. Lock: hold gray_in=8'h00, release rst -> locked=1 on edge 3, bin_out=0, change never pulses, step_err=0.
2. Stepping: drive gray_in 8'h00,01,03,02,06, each held 4 cycles -> bin_out 0,1,2,3,4. Each update lands 3 edges after the input change; change is a 1-cycle pulse; delta_out=1; step_err=0.
3. Jump: from 8'h02 (bin 3) to 8'h07 (bin 5) -> bin_out=5, delta_out=2, step_err=1 and it stays 1. Then err_clr=1 for 1 cycle -> step_err=0.
4. Wrap: 8'h80 (bin 255) to 8'h00 -> bin_out=0, delta_out=1, step_err=0.
5. Enable hold: at bin 4 drop en, step gray to bin 7 (8'h04), raise en -> bin_out=7, delta_out=3, step_err=1. Rerun with MAX_STEP=4 -> step_err=0.
6. Collision and reset: err_clr=1 on the same edge as a delta-2 capture -> step_err=1. Assert rst mid-RUN -> all outputs 0 immediately, locked=0. After release with gray_in=8'h80, relock gives bin_out=255 with no change pulse and no step_err.
